load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/load_store_unit.sv | 108 ++++++++++
 tb/tb_load_store_unit.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and
// the alignment fault rules.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic is_store(op_e op);
    logic r;
    r = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    return r;
  endfunction

  // Sub-word stores need a read-modify-write through the WRITE state.
  function automatic logic is_partial_store(op_e op);
    logic r;
    r = (op == OP_SH) || (op == OP_SB);
    return r;
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] offset);
    logic r;
    case (op)
      OP_LW, OP_SW:         r = (offset != 2'b00);
      OP_LH, OP_LHU, OP_SH: r = offset[0];
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] word_index(logic [31:0] addr);
    logic [31:0] r;
    r = {2'b00, addr[31:2]};
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-wide data memory bus of the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        misaligned;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_r_wbar;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // master: pipeline plus memory model; slave: the load/store unit
  modport master (
    output req_valid, op, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, resp_data, misaligned, stall,
           mem_addr, mem_r_wbar, mem_wdata
  );

  modport slave (
    input  req_valid, op, addr, wdata, mem_rdata,
    output req_ready, resp_valid, resp_data, misaligned, stall,
           mem_addr, mem_r_wbar, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: extract/extend a load lane from a memory word,
// and merge a store halfword/byte into a memory word.
module lsu_lane_align
  import mips_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant byte.
  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0: byte_lane = word[31:24];
      2'd1: byte_lane = word[23:16];
      2'd2: byte_lane = word[15:8];
      2'd3: byte_lane = word[7:0];
      default: byte_lane = 8'h00;
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_data = 32'h0;
    case (op)
      OP_LW:   load_data = word;
      OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_data = {16'h0000, half_lane};
      OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_data = {24'h000000, byte_lane};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merged_word = word;
    if (op == OP_SH) begin
      merged_word = offset[1] ? {word[31:16], wdata[15:0]}
                              : {wdata[15:0], word[15:0]};
    end else if (op == OP_SB) begin
      case (offset)
        2'd0: merged_word = {wdata[7:0], word[23:0]};
        2'd1: merged_word = {word[31:24], wdata[7:0], word[15:0]};
        2'd2: merged_word = {word[31:16], wdata[7:0], word[7:0]};
        2'd3: merged_word = {word[31:8], wdata[7:0]};
        default: merged_word = word;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit sitting between the memory pipeline stage and a
// word-addressed data memory with combinational read and clocked write.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | word read (loads, SH/SB) or single write cycle (SW)
// WRITE  | write-back of the merged word for SH/SB
// RESP   | one-cycle response strobe, then back to IDLE
module load_store_unit
  import mips_pkg::*;
(
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  state_e      state;
  op_e         op_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;
  op_e         op_in;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign op_in = op_e'(bus.op);

  lsu_lane_align u_lane_align (
    .op          (op_q),
    .offset      (offset_q),
    .word        (bus.mem_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      op_q           <= OP_LW;
      offset_q       <= 2'b00;
      wdata_q        <= 16'h0000;
      bus.req_ready  <= 1'b1;
      bus.stall      <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= 32'h0;
      bus.misaligned <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_r_wbar <= 1'b1;
      bus.mem_wdata  <= 32'h0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.mem_r_wbar <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            op_q          <= op_in;
            offset_q      <= bus.addr[1:0];
            wdata_q       <= bus.wdata[15:0];
            bus.mem_addr  <= word_index(bus.addr);
            bus.req_ready <= 1'b0;
            bus.stall     <= 1'b1;
            if (is_misaligned(op_in, bus.addr[1:0])) begin
              state          <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.misaligned <= 1'b1;
              bus.resp_data  <= 32'h0;
            end else begin
              state <= ST_ACCESS;
              if (op_in == OP_SW) begin
                bus.mem_r_wbar <= 1'b0;
                bus.mem_wdata  <= bus.wdata;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (is_partial_store(op_q)) begin
            // Merge against the word read this cycle; written in WRITE.
            state          <= ST_WRITE;
            bus.mem_r_wbar <= 1'b0;
            bus.mem_wdata  <= merged_word;
          end else begin
            state          <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= is_store(op_q) ? 32'h0 : load_data;
          end
        end
        ST_WRITE: begin
          state          <= ST_RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_data  <= 32'h0;
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
          bus.stall     <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
          bus.stall     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model and a
// response scoreboard.
module tb_load_store_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:255] = '{default: 32'h0};
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk)
    if (!reset && bus.mem_r_wbar === 1'b0) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input logic exp_mis);
    exp_t e;
    int   wpos;
    int   nwr;
    bit   got;
    e.data = exp_data;
    e.mis  = exp_mis;
    if (exp_mis)                     e.lat = 1;
    else if (op == SH || op == SB)   e.lat = 3;
    else                             e.lat = 2;
    if (exp_mis)                     wpos = 0;
    else if (op == SW)               wpos = 1;
    else if (op == SH || op == SB)   wpos = 2;
    else                             wpos = 0;
    sb.push_back(e);

    @(negedge clk);
    check({tag, " req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.op        = op;
    bus.addr      = addr;
    bus.wdata     = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.op        = ~op;
    bus.addr      = ~addr;
    bus.wdata     = ~wdata;

    got = 1'b0;
    nwr = 0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, " stall"}, {31'b0, bus.stall}, 32'd1);
      if (bus.mem_r_wbar === 1'b0) begin
        nwr++;
        check({tag, " write cycle"}, n, wpos);
        check({tag, " write addr"}, bus.mem_addr, {2'b00, addr[31:2]});
      end
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1;
        e = sb.pop_front();
        check({tag, " latency"}, n, e.lat);
        check({tag, " resp_data"}, bus.resp_data, e.data);
        check({tag, " misaligned"}, {31'b0, bus.misaligned}, {31'b0, e.mis});
      end
    end
    if (!got) begin
      check({tag, " response timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    check({tag, " write count"}, nwr, (wpos != 0) ? 1 : 0);
  endtask

  initial begin
    int rv;
    bus.req_valid = 1'b0;
    bus.op        = LW;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    reset         = 1'b1;
    #2;
    check("rst req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("rst stall",      {31'b0, bus.stall},      32'd0);
    check("rst mem_r_wbar", {31'b0, bus.mem_r_wbar}, 32'd1);
    check("rst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst misaligned", {31'b0, bus.misaligned}, 32'd0);
    check("rst resp_data",  bus.resp_data,  32'h0);
    check("rst mem_addr",   bus.mem_addr,   32'h0);
    check("rst mem_wdata",  bus.mem_wdata,  32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_req("sw44",   SW,  32'h44, 32'h71FD6806, 32'h0, 1'b0);
    check("mem word17", mem[17], 32'h71FD6806);
    do_req("lw44",   LW,  32'h44, 32'h0, 32'h71FD6806, 1'b0);
    do_req("lb47",   LB,  32'h47, 32'h0, 32'h00000006, 1'b0);
    do_req("lb45",   LB,  32'h45, 32'h0, 32'hFFFFFFFD, 1'b0);
    do_req("lbu45",  LBU, 32'h45, 32'h0, 32'h000000FD, 1'b0);
    do_req("lh46",   LH,  32'h46, 32'h0, 32'h00006806, 1'b0);
    do_req("lhu44",  LHU, 32'h44, 32'h0, 32'h000071FD, 1'b0);
    do_req("sb45",   SB,  32'h45, 32'h000000AA, 32'h0, 1'b0);
    do_req("lw44b",  LW,  32'h44, 32'h0, 32'h71AA6806, 1'b0);
    do_req("sh46",   SH,  32'h46, 32'h1234ABCD, 32'h0, 1'b0);
    do_req("lh46b",  LH,  32'h46, 32'h0, 32'hFFFFABCD, 1'b0);
    do_req("lw44c",  LW,  32'h44, 32'h0, 32'h71AAABCD, 1'b0);

    do_req("lw46 mis",  LW,  32'h46, 32'h0, 32'h0, 1'b1);
    do_req("sw45 mis",  SW,  32'h45, 32'hDEADBEEF, 32'h0, 1'b1);
    do_req("lh43 mis",  LH,  32'h43, 32'h0, 32'h0, 1'b1);
    do_req("lhu47 mis", LHU, 32'h47, 32'h0, 32'h0, 1'b1);
    do_req("sh41 mis",  SH,  32'h41, 32'h5555, 32'h0, 1'b1);
    do_req("lw44d",  LW,  32'h44, 32'h0, 32'h71AAABCD, 1'b0);
    do_req("sb44",   SB,  32'h40, 32'h00000077, 32'h0, 1'b0);
    do_req("lw40",   LW,  32'h40, 32'h0, 32'h77000000, 1'b0);

    do_req("sw wrap",  SW,  32'hFFFFFFFC, 32'hCAFEF00D, 32'h0, 1'b0);
    do_req("lw wrap",  LW,  32'hFFFFFFFC, 32'h0, 32'hCAFEF00D, 1'b0);
    do_req("lbu wrap", LBU, 32'hFFFFFFFF, 32'h0, 32'h0000000D, 1'b0);

    // SH aborted by reset while in WRITE
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op        = SH;
    bus.addr      = 32'h44;
    bus.wdata     = 32'h0000BEEF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("abort in write", {31'b0, bus.mem_r_wbar}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort mem_r_wbar", {31'b0, bus.mem_r_wbar}, 32'd1);
    check("abort req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("abort stall",      {31'b0, bus.stall},      32'd0);
    check("abort mem_addr",   bus.mem_addr,  32'h0);
    check("abort mem_wdata",  bus.mem_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    rv = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) rv++;
    end
    check("abort no resp", rv, 0);
    do_req("lw after abort", LW, 32'h44, 32'h0, 32'h71AAABCD, 1'b0);

    check("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
